// File: rtl/nrx_rom_dl_ctrl.sv
// ROM download sequencer: turns the ioctl byte stream into per-region ROM writes,
// checks per-region byte counts and holds the game core in reset until a good image has settled.
module nrx_rom_dl_ctrl #(
  parameter logic [99:0] RBASE = {25'h05120, 25'h05000, 25'h04000, 25'h00000},
  parameter logic [67:0] RSIZE = {17'd256, 17'd288, 17'd4096, 17'd16384},
  parameter int unsigned HOLD  = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        USR_RST,
  input  logic        DL_ACT,
  input  logic        DL_WR,
  input  logic [24:0] DL_ADDR,
  input  logic [7:0]  DL_DATA,
  output logic [3:0]  ROMWE,
  output logic [15:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        CORE_RST,
  output logic        DL_BUSY,
  output logic        DL_OK,
  output logic        DL_ERR
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_DONE, S_ERR} state_t;

  state_t      state_q;
  logic        act_q;
  logic        usr_q;
  logic        ovf_q, ovf_d;
  logic [7:0]  settle_q;
  logic [16:0] cnt_q [4];
  logic [16:0] cnt_d [4];
  logic [3:0]  romwe_q;
  logic [15:0] romad_q;
  logic [7:0]  romdt_q;

  logic        rise, fall, wr_acc, hit, img_good;
  logic [1:0]  hit_r;
  logic [15:0] local_ad;
  logic [25:0] base_ext, end_ext;

  assign rise   = DL_ACT & ~act_q;
  assign fall   = ~DL_ACT & act_q;
  assign wr_acc = DL_WR & DL_ACT;

  // Region decode; scanning from 3 down to 0 lets the lowest matching region win.
  always_comb begin
    hit      = 1'b0;
    hit_r    = 2'd0;
    local_ad = 16'd0;
    base_ext = 26'd0;
    end_ext  = 26'd0;
    for (int r = 3; r >= 0; r--) begin
      base_ext = {1'b0, RBASE[25*r +: 25]};
      end_ext  = base_ext + {9'd0, RSIZE[17*r +: 17]};
      if ({1'b0, DL_ADDR} >= base_ext && {1'b0, DL_ADDR} < end_ext) begin
        hit      = 1'b1;
        hit_r    = 2'(r);
        local_ad = 16'(DL_ADDR - RBASE[25*r +: 25]);
      end
    end
  end

  // A rise clears the counts first, so a write on the rise cycle still counts as 1.
  always_comb begin
    ovf_d    = rise ? 1'b0 : ovf_q;
    img_good = ~ovf_q;
    if (wr_acc && !hit) ovf_d = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cnt_d[r] = rise ? 17'd0 : cnt_q[r];
      if (wr_acc && hit && hit_r == 2'(r) && cnt_d[r] != 17'h1FFFF) cnt_d[r] = cnt_d[r] + 17'd1;
      if (cnt_q[r] != RSIZE[17*r +: 17]) img_good = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      act_q    <= DL_ACT;  // a download still active across reset must not look like a rise
      usr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      settle_q <= 8'd0;
      romwe_q  <= 4'd0;
      romad_q  <= 16'd0;
      romdt_q  <= 8'd0;
      for (int r = 0; r < 4; r++) cnt_q[r] <= 17'd0;
    end else begin
      act_q   <= DL_ACT;
      usr_q   <= USR_RST;
      ovf_q   <= ovf_d;
      romwe_q <= 4'd0;
      for (int r = 0; r < 4; r++) cnt_q[r] <= cnt_d[r];
      if (wr_acc && hit) begin
        romwe_q <= 4'd1 << hit_r;
        romad_q <= local_ad;
        romdt_q <= DL_DATA;
      end
      case (state_q)
        S_LOAD: begin
          if (fall) begin
            state_q  <= S_SETTLE;
            settle_q <= 8'(HOLD - 1);
          end
        end
        S_SETTLE: begin
          if (settle_q == 8'd0) state_q <= img_good ? S_DONE : S_ERR;
          else                  settle_q <= settle_q - 8'd1;
        end
        default: ;
      endcase
      if (rise) state_q <= S_LOAD;
    end
  end

  assign ROMWE    = romwe_q;
  assign ROMAD    = romad_q;
  assign ROMDT    = romdt_q;
  assign CORE_RST = usr_q | (state_q != S_DONE);
  assign DL_BUSY  = (state_q == S_LOAD) || (state_q == S_SETTLE);
  assign DL_OK    = (state_q == S_DONE);
  assign DL_ERR   = (state_q == S_ERR);

endmodule

// File: doc/nrx_rom_dl_ctrl.md
# nrx_rom_dl_ctrl

ROM download sequencer for the New Rally-X core. It sits between the HPS ioctl download stream and the game core's ROM/PROM write ports. Each downloaded byte is decoded into one of four ROM regions and becomes a one-cycle region-local write. Per-region byte counts are checked against expected sizes. The game core is held in reset until a complete, well-formed image has loaded and a settle delay has elapsed.

## Interface
Parameters:
- RBASE, {25'h05120, 25'h05000, 25'h04000, 25'h00000}: packed start address of regions 3..0 in the download stream.
- RSIZE, {17'd256, 17'd288, 17'd4096, 17'd16384}: packed byte size of regions 3..0 (sound PROM, colour/lookup PROMs, CHR ROM, CPU ROM).
- HOLD, 16: settle cycles between end of download and core reset release (1..255).

Ports:
- CLK, in, 1: system clock (24 MHz domain). This is the only clock.
- RESET, in, 1: synchronous, active-high reset.
- USR_RST, in, 1: user/OSD reset request. It is ORed into CORE_RST.
- DL_ACT, in, 1: download active (ioctl_download).
- DL_WR, in, 1: byte strobe (ioctl_wr). It is qualified by DL_ACT.
- DL_ADDR, in, 25: stream byte address.
- DL_DATA, in, 8: stream byte.
- ROMWE, out, 4: one-hot region write enable, one-cycle pulse.
- ROMAD, out, 16: region-local address (DL_ADDR − RBASE[r]).
- ROMDT, out, 8: write data.
- CORE_RST, out, 1: game core reset.
- DL_BUSY, out, 1: high in LOAD and SETTLE.
- DL_OK, out, 1: high in DONE.
- DL_ERR, out, 1: high in ERR.

## Operation
- State machine has five states: IDLE, LOAD, SETTLE, DONE, ERR.
- Reset: state goes to IDLE. Counts, ovf flag and settle counter clear. ROMWE=0, ROMAD=0, ROMDT=0, CORE_RST=1, DL_BUSY=0, DL_OK=0, DL_ERR=0.
- Edge detect: DL_ACT is registered. A rise is DL_ACT=1 while the previous value was 0. A fall is the reverse.
- Rise in any state: next state is LOAD. Counts and ovf clear.
- LOAD to SETTLE on a fall. The settle counter loads HOLD−1.
- SETTLE decrements each cycle. At 0 the next state is DONE if the image is good, else ERR.
- An image is good when no ovf occurred and, for every region, count == RSIZE[r].
- A rise during SETTLE aborts the settle and re-enters LOAD.
- DONE and ERR are held until the next rise.
- Write acceptance:
  - A write is accepted when DL_WR=1 and DL_ACT=1.
  - Region r is hit when RBASE[r] ≤ DL_ADDR < RBASE[r]+RSIZE[r]. Regions must not overlap. The lowest r wins.
  - A hit pulses ROMWE[r] and increments count[r].
  - An accepted write that hits no region sets ovf and generates no ROMWE.
- On the rise cycle, the clear takes priority and the same-cycle write is then counted, giving count=1.
- Counts are 17-bit and saturate at 17'h1FFFF. Duplicate addresses are counted again, so a repeated image over-counts and ends in ERR.
- Outputs:
  - CORE_RST = RESET_state | USR_RST_q | (state ≠ DONE). The core runs only from DONE.
  - DL_BUSY = state ∈ {LOAD, SETTLE}.
  - DL_OK = (state == DONE).
  - DL_ERR = (state == ERR).
- ROMAD is the low 16 bits of the subtraction. Region sizes above 64 KiB are not supported.

## Timing
- Write latency is 1 cycle. A strobe sampled at edge n produces ROMWE/ROMAD/ROMDT valid from edge n+1 for exactly one cycle.
- Back-to-back strobes on consecutive cycles give consecutive ROMWE pulses with no gaps and no drops.
- ROMAD and ROMDT hold their last values when ROMWE=0.
- State transitions, DL_BUSY, DL_OK and DL_ERR are registered:
  - A rise sampled at edge n gives DL_BUSY=1 from edge n+1.
  - A fall sampled at edge n gives SETTLE from n+1 and DONE/ERR from n+1+HOLD.
  - CORE_RST falls at that same edge.
- The final write, accepted in the fall's preceding cycle, lands in the counts before the SETTLE evaluation.
- USR_RST is registered once, so CORE_RST asserts 1 cycle after USR_RST. USR_RST does not change state.
- A rise in DONE asserts CORE_RST 1 cycle after the sampled rise.
- RESET mid-LOAD: the next edge returns all outputs to their reset values and discards partial counts. A download still active after RESET releases does not re-enter LOAD until a fresh rise occurs.

## Test plan
- Good image: stream 0x5220 sequential bytes at one strobe per 4 cycles, then DL_ACT=0.
  - ROMWE[0] pulses 16384 times with ROMAD 0..0x3FFF, ROMWE[1] 4096, ROMWE[2] 288, ROMWE[3] 256.
  - DL_OK=1 and CORE_RST=0 exactly HOLD+1 cycles after the fall is sampled.
- Short image: stop at byte 0x5200. Result is DL_ERR=1, CORE_RST=1, and count[3]=224.
- Out-of-range: good image plus one write at 0x06000. Result is no ROMWE for that byte, ovf set, and final state ERR.
- Back-to-back strobes: DL_WR held high for 8 cycles at addresses 0x4FFE..0x5005. ROMWE steps 2,2 then 4 ×6 on consecutive cycles. ROMAD steps 0x0FFE, 0x0FFF, 0x0000..0x0005.
- Reset mid-load: assert RESET after 1000 bytes. All outputs take reset values. A following complete download reaches DONE with count[0]=16384, with no residue from the first 1000 bytes.
- Re-download and user reset:
  - From DONE, a new rise sets CORE_RST=1 and DL_OK=0 one cycle later.
  - In DONE, USR_RST pulsed for 1 cycle gives a CORE_RST pulse of 1 cycle delayed by 1, and the state stays DONE.
